// File: rtl/lu_pkg.sv
// Shared ALU definitions: opcode encodings and the iterative FSM state type.
// Intended for reuse by other ALU blocks in the core.
package lu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOT  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lu_core.sv
// Single-cycle logic unit: bitwise ops, zero-distance shifts and illegal op.
// Purely combinational; the iterative shifter lives in lu_iter.
module lu_core
    import lu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             err
);

    always_comb begin
        res = '0;
        err = 1'b0;
        unique case (op_e'(op))
            OP_AND:         res = a & b;
            OP_OR:          res = a | b;
            OP_XOR:         res = a ^ b;
            OP_NAND:        res = ~(a & b);
            OP_NOT:         res = ~a;
            // only reached with shamt == 0, where the result is a itself
            OP_SHL, OP_SHR: res = a;
            OP_ILL:         err = 1'b1;
            default:        res = '0;
        endcase
    end

endmodule

// File: rtl/lu_iter.sv
// Iterative logic unit: one bit of shift per cycle, valid/ready on both sides.
// Results are registered and held until the consumer takes them.
module lu_iter
    import lu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_e           state;
    state_e           nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   cnt;
    logic             left;
    logic             acc;
    logic             is_shift;
    logic [WIDTH-1:0] core_res;
    logic             core_err;

    lu_core #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .a   (a),
        .b   (b),
        .res (core_res),
        .err (core_err)
    );

    assign acc       = in_valid && in_ready;
    assign is_shift  = (op == OP_SHL || op == OP_SHR) && (shamt != '0);
    assign shifted   = left ? (sreg << 1) : (sreg >> 1);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = is_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == CNT_ONE) nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) nxt = is_shift ? SHIFT : DONE;
                    else          nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Result registers only change on accept or on the final shift step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            left <= 1'b0;
            out  <= '0;
            zero <= 1'b0;
            err  <= 1'b0;
        end else if (acc) begin
            if (is_shift) begin
                sreg <= a;
                cnt  <= shamt;
                left <= (op == OP_SHL);
            end else begin
                out  <= core_res;
                zero <= (core_res == '0);
                err  <= core_err;
            end
        end else if (state == SHIFT) begin
            sreg <= shifted;
            cnt  <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                out  <= shifted;
                zero <= (shifted == '0);
                err  <= 1'b0;
            end
        end
    end

endmodule
